// File: rtl/stream_sum_consumer.sv
// Launches an upstream generator with limit n, drains its stream, and returns (sum, count, max) then a done beat.
// up_start one cycle after __start; one upstream beat per cycle; result holds until __ready. STREAM_SUM_CONSUMER_SAT_EN enables saturation and __overflow.
module stream_sum_consumer #(
    parameter int WIDTH     = 32,
    parameter int SUM_WIDTH = 48,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 __clock,
    input  logic                 __reset,
    input  logic                 __start,
    input  logic [WIDTH-1:0]     n,
    output logic                 up_start,
    output logic [WIDTH-1:0]     up_n,
    output logic                 up_ready,
    input  logic                 up_valid,
    input  logic                 up_done,
    input  logic [WIDTH-1:0]     up_data,
    input  logic                 __ready,
    output logic                 __valid,
    output logic                 __done,
    output logic [SUM_WIDTH-1:0] __output_0,
    output logic [CNT_WIDTH-1:0] __output_1,
    output logic [WIDTH-1:0]     __output_2
`ifdef STREAM_SUM_CONSUMER_SAT_EN
    ,
    output logic                 __overflow
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        CONSUME,
        RESULT,
        FINISH
    } state_t;

    localparam logic signed [WIDTH-1:0] MAX_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                      state;
    logic signed [SUM_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]        cnt;
    logic signed [WIDTH-1:0]     mx;

    logic                        beat;
    logic signed [SUM_WIDTH-1:0] data_ext;
    logic signed [SUM_WIDTH-1:0] sum_wrap;
    logic signed [SUM_WIDTH-1:0] sum_next;
    logic [CNT_WIDTH-1:0]        cnt_next;
    logic signed [WIDTH-1:0]     mx_next;

    assign beat     = (state == CONSUME) && up_valid && up_ready;
    assign data_ext = SUM_WIDTH'($signed(up_data));
    assign sum_wrap = sum + data_ext;
    assign mx_next  = ($signed(up_data) > mx) ? $signed(up_data) : mx;

`ifdef STREAM_SUM_CONSUMER_SAT_EN
    localparam logic signed [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};

    logic sum_ovf;
    logic cnt_full;
    logic ovf_run;

    // Signed overflow: both addends share a sign that the wrapped result lost.
    assign sum_ovf  = (sum[SUM_WIDTH-1] == data_ext[SUM_WIDTH-1]) &&
                      (sum_wrap[SUM_WIDTH-1] != sum[SUM_WIDTH-1]);
    assign cnt_full = &cnt;
    assign sum_next = sum_ovf ? (sum[SUM_WIDTH-1] ? SUM_MIN : SUM_MAX) : sum_wrap;
    assign cnt_next = cnt_full ? cnt : cnt + 1'b1;
`else
    assign sum_next = sum_wrap;
    assign cnt_next = cnt + 1'b1;
`endif

    always_ff @(posedge __clock or posedge __reset) begin
        if (__reset) begin
            state      <= IDLE;
            up_start   <= 1'b0;
            up_ready   <= 1'b0;
            up_n       <= '0;
            __valid    <= 1'b0;
            __done     <= 1'b0;
            __output_0 <= '0;
            __output_1 <= '0;
            __output_2 <= '0;
            sum        <= '0;
            cnt        <= '0;
            mx         <= '0;
`ifdef STREAM_SUM_CONSUMER_SAT_EN
            ovf_run    <= 1'b0;
            __overflow <= 1'b0;
`endif
        end else if (__start) begin
            // Restart from any state; the pulse itself comes out of LAUNCH.
            state      <= LAUNCH;
            up_start   <= 1'b1;
            up_ready   <= 1'b0;
            up_n       <= n;
            __valid    <= 1'b0;
            __done     <= 1'b0;
            sum        <= '0;
            cnt        <= '0;
            mx         <= MAX_INIT;
`ifdef STREAM_SUM_CONSUMER_SAT_EN
            ovf_run    <= 1'b0;
            __overflow <= 1'b0;
`endif
        end else begin
            case (state)
                LAUNCH: begin
                    up_start <= 1'b0;
                    up_ready <= 1'b1;
                    state    <= CONSUME;
                end
                CONSUME: begin
                    if (beat) begin
                        if (up_done) begin
                            __output_0 <= sum;
                            __output_1 <= cnt;
                            __output_2 <= mx;
                            __valid    <= 1'b1;
                            up_ready   <= 1'b0;
                            state      <= RESULT;
`ifdef STREAM_SUM_CONSUMER_SAT_EN
                            __overflow <= ovf_run;
`endif
                        end else begin
                            sum <= sum_next;
                            cnt <= cnt_next;
                            mx  <= mx_next;
`ifdef STREAM_SUM_CONSUMER_SAT_EN
                            if (sum_ovf || cnt_full) begin
                                ovf_run <= 1'b1;
                            end
`endif
                        end
                    end
                end
                RESULT: begin
                    if (__ready) begin
                        __done <= 1'b1;
                        state  <= FINISH;
                    end
                end
                FINISH: begin
                    if (__ready) begin
                        __valid <= 1'b0;
                        __done  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    up_start <= 1'b0;
                    up_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sum_consumer.sv
// Bench for stream_sum_consumer: a 48-bit and a 32-bit sum instance run in lockstep from one upstream model.
module tb_stream_sum_consumer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] n;
    logic        up_valid;
    logic        up_done;
    logic [31:0] up_data;
    logic        rdy;

    logic        up_start_a, up_ready_a, valid_a, done_a;
    logic [31:0] up_n_a;
    logic [47:0] o0_a;
    logic [15:0] o1_a;
    logic [31:0] o2_a;

    logic        up_start_b, up_ready_b, valid_b, done_b;
    logic [31:0] up_n_b;
    logic [31:0] o0_b;
    logic [15:0] o1_b;
    logic [31:0] o2_b;
`ifdef STREAM_SUM_CONSUMER_SAT_EN
    logic        ovf_a, ovf_b;
`endif

    always #5 clk = ~clk;

    stream_sum_consumer #(.WIDTH(32), .SUM_WIDTH(48), .CNT_WIDTH(16)) dut_a (
        .__clock(clk), .__reset(rst), .__start(start), .n(n),
        .up_start(up_start_a), .up_n(up_n_a), .up_ready(up_ready_a),
        .up_valid(up_valid), .up_done(up_done), .up_data(up_data),
        .__ready(rdy), .__valid(valid_a), .__done(done_a),
        .__output_0(o0_a), .__output_1(o1_a), .__output_2(o2_a)
`ifdef STREAM_SUM_CONSUMER_SAT_EN
        , .__overflow(ovf_a)
`endif
    );

    stream_sum_consumer #(.WIDTH(32), .SUM_WIDTH(32), .CNT_WIDTH(16)) dut_b (
        .__clock(clk), .__reset(rst), .__start(start), .n(n),
        .up_start(up_start_b), .up_n(up_n_b), .up_ready(up_ready_b),
        .up_valid(up_valid), .up_done(up_done), .up_data(up_data),
        .__ready(rdy), .__valid(valid_b), .__done(done_b),
        .__output_0(o0_b), .__output_1(o1_b), .__output_2(o2_b)
`ifdef STREAM_SUM_CONSUMER_SAT_EN
        , .__overflow(ovf_b)
`endif
    );

    typedef struct {
        logic [47:0] s48;
        logic [31:0] s32;
        logic [15:0] c;
        logic [31:0] m;
        logic        ov_b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   results = 0;
    int   dones = 0;
    logic expect_done = 1'b0;
    logic prev_done_hs = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [47:0] s48, input logic [31:0] s32,
                        input logic [15:0] c, input logic [31:0] m, input logic ov_b);
        exp_t e;
        e.s48 = s48; e.s32 = s32; e.c = c; e.m = m; e.ov_b = ov_b;
        q.push_back(e);
    endtask

    // Scoreboard monitor: result beats compared against the queue head every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            expect_done  = 1'b0;
            prev_done_hs = 1'b0;
        end else begin
            if (prev_done_hs) chk("idle_after_done", {63'd0, valid_a}, 64'd0);
            prev_done_hs = 1'b0;
            if (valid_a) begin
                chk("done_phase", {63'd0, done_a}, {63'd0, expect_done});
                chk("lockstep_b", {62'd0, valid_b, done_b}, {62'd0, valid_a, done_a});
                if (!expect_done) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got sum %h with empty queue", o0_a);
                    end else begin
                        chk("sum48", {16'd0, o0_a}, {16'd0, q[0].s48});
                        chk("sum32", {32'd0, o0_b}, {32'd0, q[0].s32});
                        chk("count", {48'd0, o1_a}, {48'd0, q[0].c});
                        chk("max",   {32'd0, o2_a}, {32'd0, q[0].m});
`ifdef STREAM_SUM_CONSUMER_SAT_EN
                        chk("ovf_a", {63'd0, ovf_a}, 64'd0);
                        chk("ovf_b", {63'd0, ovf_b}, {63'd0, q[0].ov_b});
`endif
                        if (rdy) begin
                            void'(q.pop_front());
                            expect_done = 1'b1;
                            results++;
                        end
                    end
                end else if (rdy) begin
                    expect_done  = 1'b0;
                    prev_done_hs = 1'b1;
                    dones++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] nv);
        start = 1'b1;
        n     = nv;
        tick();
        start = 1'b0;
        n     = 32'hDEAD_BEEF;
        chk("up_start_pulse", {63'd0, up_start_a}, 64'd1);
        chk("up_ready_launch", {63'd0, up_ready_a}, 64'd0);
        tick();
        chk("up_start_single", {63'd0, up_start_a}, 64'd0);
        chk("up_n", {32'd0, up_n_a}, {32'd0, nv});
    endtask

    task automatic beat(input logic [31:0] d, input logic dn);
        int w;
        w        = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_done  = dn;
        @(negedge clk);
        while (!up_ready_a && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!up_ready_a) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: up_ready %b required 1", up_ready_a);
        end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_done  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || expect_done) && w < 40) begin
            tick();
            w++;
        end
        if (q.size() != 0 || expect_done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: queue %0d pending_done %b required 0 0", q.size(), expect_done);
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; n = '0; up_valid = 1'b0; up_done = 1'b0;
        up_data = '0; rdy = 1'b1;
        tick();
        tick();
        chk("rst_valid", {62'd0, valid_a, done_a}, 64'd0);
        chk("rst_up", {62'd0, up_start_a, up_ready_a}, 64'd0);
        chk("rst_outputs", {o0_a, o1_a}, 64'd0);
        chk("rst_max_upn", {o2_a, up_n_a}, 64'd0);
        rst = 1'b0;
        tick();

        // 5, -3, 7: done beat carries junk data that must not be added
        do_start(32'd3);
        push(48'd9, 32'd9, 16'd3, 32'd7, 1'b0);
        beat(32'd5, 1'b0);
        beat(-32'sd3, 1'b0);
        beat(32'd7, 1'b0);
        beat(32'h7FFF_FFF0, 1'b1);
        drain();

        // Empty stream
        do_start(32'd0);
        push(48'd0, 32'd0, 16'd0, 32'h8000_0000, 1'b0);
        beat(32'h1234_5678, 1'b1);
        drain();

        // All negative stream with result stalled 5 cycles
        rdy = 1'b0;
        do_start(32'd3);
        push(48'hFFFF_FFFF_FFEF, 32'hFFFF_FFEF, 16'd3, 32'hFFFF_FFFD, 1'b0);
        beat(-32'sd5, 1'b0);
        beat(-32'sd3, 1'b0);
        beat(-32'sd9, 1'b0);
        beat(32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {63'd0, valid_a}, 64'd1);
            tick();
        end
        rdy = 1'b1;
        drain();

        // Restart after 2 of 4 beats abandons the first run
        do_start(32'd4);
        beat(32'd10, 1'b0);
        beat(32'd20, 1'b0);
        do_start(32'd2);
        push(48'd3, 32'd3, 16'd2, 32'd2, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd0, 1'b1);
        drain();

        // Sum overflow of the 32-bit instance
        do_start(32'd2);
`ifdef STREAM_SUM_CONSUMER_SAT_EN
        push(48'h0000_8000_0000, 32'h7FFF_FFFF, 16'd2, 32'h7FFF_FFFF, 1'b1);
`else
        push(48'h0000_8000_0000, 32'h8000_0000, 16'd2, 32'h7FFF_FFFF, 1'b0);
`endif
        beat(32'h7FFF_FFFF, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd0, 1'b1);
        drain();

        // Asynchronous reset between edges during CONSUME
        do_start(32'd4);
        beat(32'd10, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {62'd0, valid_a, done_a}, 64'd0);
        chk("arst_up", {62'd0, up_start_a, up_ready_a}, 64'd0);
        chk("arst_outputs", {o0_a, o1_a}, 64'd0);
        chk("arst_max_upn", {o2_a, up_n_a}, 64'd0);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | up_start_a | up_ready_a;
        end
        chk("no_launch_after_rst", {63'd0, seen}, 64'd0);

        chk("results_seen", 64'(results), 64'd5);
        chk("dones_seen", 64'(dones), 64'd5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_sum_consumer.md
Name: stream_sum_consumer

Overview:
- Consumer end of the codebase's generator ready/valid/done stream protocol.
- Launches an upstream generator with a limit `n` and drains its output stream.
- Accumulates running sum, beat count and maximum of the streamed values.
- Presents the result as a single output tuple followed by a done beat, using the same protocol on its own downstream side, so it can be chained behind any generated generator module.

Parameters:
- WIDTH, 32, signed width of upstream data and of `n`.
- SUM_WIDTH, 48, signed width of the sum accumulator.
- CNT_WIDTH, 16, unsigned width of the beat counter.

Ports:
- __clock  input  1  single clock, all logic on posedge.
- __reset  input  1  asynchronous, active-high reset.
- __start  input  1  capture `n` this cycle and (re)start a run.
- n  input  WIDTH  limit forwarded to upstream; sampled only when __start is high.
- up_start  output  1  one-cycle start pulse to upstream generator.
- up_n  output  WIDTH  limit presented to upstream; stable while up_start is high.
- up_ready  output  1  consumer ready for upstream beat.
- up_valid  input  1  upstream beat valid.
- up_done  input  1  upstream finished; beat carries no data.
- up_data  input  WIDTH  upstream data (generator __output_0).
- __ready  input  1  downstream ready.
- __valid  output  1  downstream beat valid.
- __done  output  1  downstream done beat.
- __output_0  output  SUM_WIDTH  sum.
- __output_1  output  CNT_WIDTH  count.
- __output_2  output  WIDTH  maximum.

Behaviour:
- Async reset: state IDLE; up_start, up_ready, __valid, __done = 0; __output_0, __output_1 = 0; __output_2 = 0; up_n = 0; accumulators cleared. Reset dominates __start.
- States: IDLE, LAUNCH, CONSUME, RESULT, FINISH.
- __start (any state):
  - latch up_n <= n; sum = 0, count = 0, max = -2^(WIDTH-1);
  - __valid = 0, __done = 0;
  - next state LAUNCH.
  - __start mid-run abandons the current run; it does not pulse up_start directly.
- LAUNCH (1 cycle): up_start = 1, up_ready = 0; next CONSUME. Latency from __start to up_start is exactly 1 cycle.
- CONSUME: up_ready = 1. A beat is accepted when up_valid && up_ready.
  - Accepted beat with up_done = 0:
    - sum += sign-extended up_data, wrapping mod 2^SUM_WIDTH;
    - count += 1, wrapping;
    - max = up_data if up_data > max (signed compare).
  - Accepted beat with up_done = 1: up_data ignored; register outputs (__output_0 = sum, __output_1 = count, __output_2 = max); __valid = 1; up_ready = 0 from the next cycle; next RESULT.
  - A beat with up_valid && up_done in the same cycle as data is treated as done only.
  - Throughput: one beat per cycle.
- RESULT: hold __valid = 1 and outputs stable until __ready.
  - On __ready: __valid = 1, __done = 1, outputs unchanged; next FINISH.
- FINISH: hold __valid = __done = 1 until __ready; then __valid = __done = 0; next IDLE.
- IDLE: up_ready = 0, up_start = 0; outputs retain their last values.
- Empty stream (upstream done first): result sum 0, count 0, max -2^(WIDTH-1).
- up_valid outside CONSUME is ignored (up_ready = 0).

Optional Feature:
- Macro: STREAM_SUM_CONSUMER_SAT_EN.
- Defined:
  - sum saturates at +(2^(SUM_WIDTH-1)-1) / -2^(SUM_WIDTH-1);
  - count saturates at 2^CNT_WIDTH-1;
  - extra output port __overflow (1 bit, reset 0) is set with the result beat if any saturation occurred in the run, and cleared on __start.
- Undefined: wrap-around arithmetic, no __overflow port.

Test Plan:
- Upstream model emits 5, -3, 7 then done, __ready held high → up_start exactly 1 cycle after __start; result beat sum = 9, count = 3, max = 7; next cycle done beat; then idle.
- Upstream done immediately (n = 0) → result sum = 0, count = 0, max = 0x80000000, followed by done beat.
- Result presented with __ready low for 5 cycles → __valid stays 1, outputs unchanged, __done stays 0; handshake on cycle 6 → done beat next.
- __start asserted after 2 of 4 beats (10, 20) → up_start re-pulsed; new stream 1, 2 yields sum = 3, count = 2, max = 2.
- __reset pulsed mid-CONSUME between clock edges → all outputs 0 immediately; no up_start until next __start.
- With STREAM_SUM_CONSUMER_SAT_EN and SUM_WIDTH = 32, stream 2147483647, 1 → sum = 2147483647, __overflow = 1; without the macro → sum = -2147483648.
